ip_codma_bus_arbiter: RTL and testbench
=======================================

IP_CODMA_BUS_ARBITER -- requirements
Module: ip_codma_bus_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk_i (input, 1, rising-edge clock) and reset_i (input, 1, synchronous, active-high reset).
REQ-002 Master ports SHALL be provided for N in {0,1}; m0 is the DMA engine and m1 is the secondary master:
- mN_read_i  in  1  read request
- mN_write_i  in  1  write request
- mN_addr_i  in  32  start byte address
- mN_size_i  in  4  beat-size code
- mN_write_valid_i  in  1  write beat valid
- mN_write_data_i  in  64  write beat data
- mN_grant_o  out  1  master owns the bus
- mN_read_valid_o  out  1  read beat valid
- mN_read_data_o  out  64  read beat data
- mN_done_o  out  1  one-cycle pulse at transfer end
- mN_error_o  out  1  one-cycle pulse on rejected or aborted transfer
REQ-003 The memory-side port SHALL be:
- s_read_o, s_write_o  out  1  request
- s_addr_o  out  32
- s_size_o  out  4
- s_write_valid_o  out  1
- s_write_data_o  out  64
- s_grant_i  in  1
- s_read_valid_i  in  1
- s_read_data_i  in  64

Function
REQ-004 The FSM states SHALL be IDLE, REQ, XFER and DONE; any other encoding SHALL go to IDLE on the next cycle and pulse the owner's mN_error_o.
REQ-005 In IDLE, a master SHALL be requesting when its read or write input is high. Read and write both high together SHALL be treated as a read.
REQ-006 Arbitration SHALL be round-robin. On simultaneous requests, the master that did not own the last transfer SHALL win; after reset, m0 SHALL win.
REQ-007 On a win, the FSM SHALL go to REQ. It SHALL latch owner, direction, addr and size in that cycle, and assert mN_grant_o from REQ until DONE inclusive.
REQ-008 Size codes 0-3 SHALL mean 1, 2, 4 and 8 beats of 64 bits. A code above 3 SHALL not enter REQ: that master gets a one-cycle mN_error_o, it loses the round-robin turn, and the FSM stays in IDLE.
REQ-009 In REQ, s_read_o or s_write_o SHALL be driven high with the latched s_addr_o and s_size_o until s_grant_i is sampled high. The FSM SHALL then go to XFER.
REQ-010 In XFER, s_addr_o and s_size_o SHALL stay held.
- Reads: s_read_valid_i and s_read_data_i SHALL pass combinationally to the owner's mN_read_valid_o and mN_read_data_o.
- Writes: the owner's write_valid and write_data SHALL pass to s_write_valid_o and s_write_data_o.
REQ-011 A 4-bit beat counter SHALL reset to 0 on entering XFER and increment on each valid beat. When the beat count reaches the expected total, the FSM SHALL go to DONE.
REQ-012 DONE SHALL last one cycle, pulse the owner's mN_done_o, update the last-owner flag and return to IDLE. A new transfer can therefore start no earlier than the cycle after DONE.
REQ-013 The non-owner's grant, read_valid, done and error outputs SHALL stay 0. Its requests SHALL be held pending and never dropped.
REQ-014 Outside REQ and XFER, s_read_o, s_write_o and s_write_valid_o SHALL be 0, s_size_o SHALL be 9 (idle code), and all data and address outputs SHALL be 0.
REQ-015 A requester that deasserts its request before winning SHALL be ignored. Once latched, changes to a master's request inputs during REQ or XFER SHALL be ignored.

Reset
REQ-016 Reset SHALL put the FSM in IDLE, clear the beat counter, owner and last-owner (last-owner = m1, so m0 wins first), and clear the timeout counter.
REQ-017 During reset, every output SHALL be 0 except s_size_o = 9. Reset asserted mid-transfer SHALL abandon the transfer with no done or error pulse.

Configuration
REQ-018 Macro IP_CODMA_ARB_TIMEOUT_EN SHALL control a watchdog.
- Defined: an 8-bit counter SHALL count consecutive REQ/XFER cycles with no grant or beat. On reaching 255 it SHALL abort to IDLE, pulse the owner's mN_error_o with no done pulse, and clear the counter on any progress.
- Undefined: there SHALL be no counter or logic, and the FSM SHALL wait indefinitely.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- m0 read, size 2, s_grant_i after 3 cycles, 4 read beats -> m0_grant_o for the whole transfer, 4 m0_read_valid_o beats in order, one m0_done_o pulse.
- m0 and m1 both request from reset -> m0 served first; then m1 served; then m1 and m0 together again -> m0 served, confirming round-robin alternation.
- m1 write, size 1, data 0xA5A5_0000_0000_0001 and 0x2 -> s_write_data_o carries both beats; m1_done_o after the second beat.
- m0 request with size 5 -> m0_error_o for one cycle, no s_read_o or s_write_o, FSM stays in IDLE.
- reset_i asserted in XFER after 2 of 8 beats -> next cycle all outputs idle, s_size_o = 9, no done pulse.
- With IP_CODMA_ARB_TIMEOUT_EN defined, s_grant_i held low -> m0_error_o after 255 REQ cycles and return to IDLE. With the macro undefined, the FSM is still in REQ after 1000 cycles.

Source files
------------

// File: rtl/ip_codma_bus_arbiter.sv
// Two-master round-robin arbiter between the CODMA engine (m0), a secondary master (m1) and one memory port.
// Optional watchdog abort on stalled transfers is enabled by defining IP_CODMA_ARB_TIMEOUT_EN.
module ip_codma_bus_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_read_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_size_i,
  input  logic        m0_write_valid_i,
  input  logic [63:0] m0_write_data_i,
  output logic        m0_grant_o,
  output logic        m0_read_valid_o,
  output logic [63:0] m0_read_data_o,
  output logic        m0_done_o,
  output logic        m0_error_o,
  input  logic        m1_read_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_size_i,
  input  logic        m1_write_valid_i,
  input  logic [63:0] m1_write_data_i,
  output logic        m1_grant_o,
  output logic        m1_read_valid_o,
  output logic [63:0] m1_read_data_o,
  output logic        m1_done_o,
  output logic        m1_error_o,
  output logic        s_read_o,
  output logic        s_write_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_size_o,
  output logic        s_write_valid_o,
  output logic [63:0] s_write_data_o,
  input  logic        s_grant_i,
  input  logic        s_read_valid_i,
  input  logic [63:0] s_read_data_i
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;

  localparam logic [SIZE_W-1:0] SIZE_IDLE = SIZE_W'(9);
  localparam logic [SIZE_W-1:0] SIZE_MAX  = SIZE_W'(3);

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              last_q, last_d;
  logic [1:0]        err_q, err_d;

`ifdef IP_CODMA_ARB_TIMEOUT_EN
  logic [7:0]        wdog_q, wdog_d;
`endif

  logic              req0, req1, win, sel_read, beat;
  logic [SIZE_W-1:0] sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [CNT_W-1:0]  beat_total;

  // Simultaneous requests go to whichever master did not own the last transfer.
  assign req0       = m0_read_i | m0_write_i;
  assign req1       = m1_read_i | m1_write_i;
  assign win        = (req0 && req1) ? ~last_q : req1;
  assign sel_read   = win ? m1_read_i : m0_read_i;
  assign sel_size   = win ? m1_size_i : m0_size_i;
  assign sel_addr   = win ? m1_addr_i : m0_addr_i;
  assign beat_total = CNT_W'(1) << size_q[1:0];
  assign beat       = (state_q == ST_XFER) &&
                      (write_q ? (owner_q ? m1_write_valid_i : m0_write_valid_i) : s_read_valid_i);

  // Next-state and latch logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    size_d  = size_q;
    beat_d  = beat_q;
    last_d  = last_q;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          if (sel_size > SIZE_MAX) begin
            err_d[win] = 1'b1;
            last_d     = win;
          end else begin
            state_d = ST_REQ;
            owner_d = win;
            write_d = ~sel_read;
            addr_d  = sel_addr;
            size_d  = sel_size;
          end
        end
      end
      ST_REQ: begin
        if (s_grant_i) begin
          state_d = ST_XFER;
          beat_d  = '0;
        end
      end
      ST_XFER: begin
        if (beat) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_d == beat_total) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d        = ST_IDLE;
        err_d[owner_q] = 1'b1;
      end
    endcase

`ifdef IP_CODMA_ARB_TIMEOUT_EN
    // Watchdog counts stalled REQ/XFER cycles; any grant or beat restarts it.
    wdog_d = '0;
    if ((state_q == ST_REQ) || (state_q == ST_XFER)) begin
      if (((state_q == ST_REQ) && s_grant_i) || beat) begin
        wdog_d = '0;
      end else if (wdog_q == 8'd254) begin
        state_d        = ST_IDLE;
        err_d          = '0;
        err_d[owner_q] = 1'b1;
        wdog_d         = '0;
      end else begin
        wdog_d = wdog_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      beat_q  <= '0;
      last_q  <= 1'b1;
      err_q   <= '0;
`ifdef IP_CODMA_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef IP_CODMA_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  // Output decode; everything is forced idle while reset is asserted.
  logic act, in_req, in_xfer, owned, rd_path, wr_path;
  assign act     = ~reset_i;
  assign in_req  = act && (state_q == ST_REQ);
  assign in_xfer = act && (state_q == ST_XFER);
  assign owned   = in_req || in_xfer || (act && (state_q == ST_DONE));
  assign rd_path = in_xfer && !write_q;
  assign wr_path = in_xfer && write_q;

  assign m0_grant_o      = owned && !owner_q;
  assign m1_grant_o      = owned && owner_q;
  assign m0_read_valid_o = rd_path && !owner_q && s_read_valid_i;
  assign m1_read_valid_o = rd_path && owner_q && s_read_valid_i;
  assign m0_read_data_o  = (rd_path && !owner_q) ? s_read_data_i : '0;
  assign m1_read_data_o  = (rd_path && owner_q) ? s_read_data_i : '0;
  assign m0_done_o       = act && (state_q == ST_DONE) && !owner_q;
  assign m1_done_o       = act && (state_q == ST_DONE) && owner_q;
  assign m0_error_o      = act && err_q[0];
  assign m1_error_o      = act && err_q[1];

  assign s_read_o        = in_req && !write_q;
  assign s_write_o       = in_req && write_q;
  assign s_addr_o        = (in_req || in_xfer) ? addr_q : '0;
  assign s_size_o        = (in_req || in_xfer) ? size_q : SIZE_IDLE;
  assign s_write_valid_o = wr_path && (owner_q ? m1_write_valid_i : m0_write_valid_i);
  assign s_write_data_o  = wr_path ? (owner_q ? m1_write_data_i : m0_write_data_i) : DATA_W'(0);

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// Scoreboard bench for ip_codma_bus_arbiter: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_ip_codma_bus_arbiter;

  logic        clk_i, reset_i;
  logic        m0_read_i, m0_write_i, m0_write_valid_i;
  logic [31:0] m0_addr_i;
  logic [3:0]  m0_size_i;
  logic [63:0] m0_write_data_i;
  logic        m0_grant_o, m0_read_valid_o, m0_done_o, m0_error_o;
  logic [63:0] m0_read_data_o;
  logic        m1_read_i, m1_write_i, m1_write_valid_i;
  logic [31:0] m1_addr_i;
  logic [3:0]  m1_size_i;
  logic [63:0] m1_write_data_i;
  logic        m1_grant_o, m1_read_valid_o, m1_done_o, m1_error_o;
  logic [63:0] m1_read_data_o;
  logic        s_read_o, s_write_o, s_write_valid_o, s_grant_i, s_read_valid_i;
  logic [31:0] s_addr_o;
  logic [3:0]  s_size_o;
  logic [63:0] s_write_data_o, s_read_data_i;

  ip_codma_bus_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .m0_read_i(m0_read_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i), .m0_size_i(m0_size_i),
    .m0_write_valid_i(m0_write_valid_i), .m0_write_data_i(m0_write_data_i),
    .m0_grant_o(m0_grant_o), .m0_read_valid_o(m0_read_valid_o), .m0_read_data_o(m0_read_data_o),
    .m0_done_o(m0_done_o), .m0_error_o(m0_error_o),
    .m1_read_i(m1_read_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i), .m1_size_i(m1_size_i),
    .m1_write_valid_i(m1_write_valid_i), .m1_write_data_i(m1_write_data_i),
    .m1_grant_o(m1_grant_o), .m1_read_valid_o(m1_read_valid_o), .m1_read_data_o(m1_read_data_o),
    .m1_done_o(m1_done_o), .m1_error_o(m1_error_o),
    .s_read_o(s_read_o), .s_write_o(s_write_o), .s_addr_o(s_addr_o), .s_size_o(s_size_o),
    .s_write_valid_o(s_write_valid_o), .s_write_data_o(s_write_data_o),
    .s_grant_i(s_grant_i), .s_read_valid_i(s_read_valid_i), .s_read_data_i(s_read_data_i)
  );

  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_DONE = 2'd2, K_ERR = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic        m;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s act=%h req=%h", name, act, req);
    else n_pass++;
  endtask

  task automatic push(input logic [1:0] k, input logic m, input logic [63:0] d);
    exp_t e;
    e.kind = k; e.m = m; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic got(input logic [1:0] k, input logic m, input logic [63:0] d, input logic g);
    exp_t e;
    n_chk++;
    if (sb_q.size() == 0) begin
      $display("FAIL unexpected_event act_kind=%0d act_m=%0d act_data=%h req=none", k, m, d);
    end else begin
      e = sb_q.pop_front();
      if (e.kind !== k || e.m !== m || e.data !== d || g !== 1'b1)
        $display("FAIL event act_kind=%0d act_m=%0d act_data=%h act_grant=%b req_kind=%0d req_m=%0d req_data=%h req_grant=1",
                 k, m, d, g, e.kind, e.m, e.data);
      else n_pass++;
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (m0_read_valid_o) got(K_RD, 1'b0, m0_read_data_o, m0_grant_o);
    if (m1_read_valid_o) got(K_RD, 1'b1, m1_read_data_o, m1_grant_o);
    if (s_write_valid_o) got(K_WR, m1_grant_o, s_write_data_o, m0_grant_o ^ m1_grant_o);
    if (m0_done_o)       got(K_DONE, 1'b0, 64'd0, m0_grant_o);
    if (m1_done_o)       got(K_DONE, 1'b1, 64'd0, m1_grant_o);
    if (m0_error_o)      got(K_ERR, 1'b0, 64'd0, 1'b1);
    if (m1_error_o)      got(K_ERR, 1'b1, 64'd0, 1'b1);
  end

  function automatic logic gnt(input logic m);
    return m ? m1_grant_o : m0_grant_o;
  endfunction

  task automatic set_req(input logic m, input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] sz);
    if (!m) begin m0_read_i = rd; m0_write_i = wr; m0_addr_i = a; m0_size_i = sz; end
    else    begin m1_read_i = rd; m1_write_i = wr; m1_addr_i = a; m1_size_i = sz; end
  endtask

  task automatic clear_req(input logic m);
    set_req(m, 1'b0, 1'b0, 32'd0, 4'd0);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  // Serves one transfer for master m; returns early after 'stop' beats if stop is below the total.
  task automatic run_xfer(input logic m, input logic wr, input logic [3:0] sz, input logic [31:0] a,
                          input int gdly, input logic [63:0] d0, input logic [63:0] d1, input int stop);
    int nb;
    logic [63:0] d;
    nb = 1 << sz[1:0];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      if (gnt(m)) break;
    end
    chk("grant_won", 64'(gnt(m)), 64'd1);
    clear_req(m);
    chk("s_addr_req", 64'(s_addr_o), 64'(a));
    chk("s_size_req", 64'(s_size_o), 64'(sz));
    chk("s_dir_req", 64'(wr ? s_write_o : s_read_o), 64'd1);
    repeat (gdly) begin
      @(posedge clk_i); #1;
      chk("req_hold", 64'(wr ? s_write_o : s_read_o), 64'd1);
    end
    s_grant_i = 1'b1;
    @(posedge clk_i); #1;
    s_grant_i = 1'b0;
    for (int i = 0; i < nb && i < stop; i++) begin
      d = (i == 0) ? d0 : d1 + 64'(i - 1);
      if (wr) begin
        if (!m) begin m0_write_valid_i = 1'b1; m0_write_data_i = d; end
        else    begin m1_write_valid_i = 1'b1; m1_write_data_i = d; end
        push(K_WR, m, d);
      end else begin
        s_read_valid_i = 1'b1; s_read_data_i = d;
        push(K_RD, m, d);
      end
      @(posedge clk_i); #1;
    end
    s_read_valid_i = 1'b0; s_read_data_i = '0;
    m0_write_valid_i = 1'b0; m0_write_data_i = '0;
    m1_write_valid_i = 1'b0; m1_write_data_i = '0;
    if (stop < nb) return;
    push(K_DONE, m, 64'd0);
    @(posedge clk_i); #1;
  endtask

  int n_req;

  initial begin
    reset_i = 1'b1;
    clear_req(1'b0); clear_req(1'b1);
    m0_write_valid_i = 1'b0; m0_write_data_i = '0;
    m1_write_valid_i = 1'b0; m1_write_data_i = '0;
    s_grant_i = 1'b0; s_read_valid_i = 1'b0; s_read_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_s_size", 64'(s_size_o), 64'd9);
    chk("rst_s_req", 64'({s_read_o, s_write_o, s_write_valid_o}), 64'd0);
    chk("rst_s_addr", 64'(s_addr_o), 64'd0);
    chk("rst_s_wdata", s_write_data_o, 64'd0);
    chk("rst_grants", 64'({m0_grant_o, m1_grant_o}), 64'd0);
    chk("rst_pulses", 64'({m0_done_o, m1_done_o, m0_error_o, m1_error_o}), 64'd0);
    reset_i = 1'b0;

    // m0 read, 4 beats, slave grant after three REQ cycles.
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_1000, 4'd2);
    run_xfer(1'b0, 1'b0, 4'd2, 32'h0000_1000, 3, 64'h1111_0000_0000_0000, 64'h1111_0000_0000_0001, 99);

    // Round-robin from reset: m0, then pending m1, then m0 again.
    pulse_reset();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'd0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0000_0080, 4'd0);
    run_xfer(1'b0, 1'b0, 4'd0, 32'h0000_0040, 0, 64'h0A0A, 64'd0, 99);
    run_xfer(1'b1, 1'b0, 4'd0, 32'h0000_0080, 0, 64'h0B0B, 64'd0, 99);
    set_req(1'b1, 1'b1, 1'b1, 32'h0000_00C0, 4'd1);
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0100, 4'd0);
    run_xfer(1'b0, 1'b0, 4'd0, 32'h0000_0100, 1, 64'h0C0C, 64'd0, 99);
    run_xfer(1'b1, 1'b0, 4'd1, 32'h0000_00C0, 0, 64'h0D0D, 64'h0D0E, 99);

    // m1 write, 2 beats.
    set_req(1'b1, 1'b0, 1'b1, 32'h0000_2000, 4'd1);
    run_xfer(1'b1, 1'b1, 4'd1, 32'h0000_2000, 0, 64'hA5A5_0000_0000_0001, 64'h2, 99);

    // Illegal size code: one error pulse, no memory request.
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_3000, 4'd5);
    push(K_ERR, 1'b0, 64'd0);
    @(posedge clk_i); #1;
    clear_req(1'b0);
    chk("badsz_no_req", 64'({s_read_o, s_write_o}), 64'd0);
    chk("badsz_size_idle", 64'(s_size_o), 64'd9);
    @(posedge clk_i); #1;
    chk("badsz_stay_idle", 64'({m0_grant_o, s_read_o}), 64'd0);

    // Reset after 2 of 8 read beats.
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_4000, 4'd3);
    run_xfer(1'b0, 1'b0, 4'd3, 32'h0000_4000, 0, 64'h4000, 64'h4001, 2);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("abort_size_idle", 64'(s_size_o), 64'd9);
    chk("abort_outputs", 64'({m0_grant_o, s_read_o, s_write_o, m0_read_valid_o}), 64'd0);
    chk("abort_addr", 64'(s_addr_o), 64'd0);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort_no_regrant", 64'({m0_grant_o, m1_grant_o}), 64'd0);

    // Stalled slave grant.
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_5000, 4'd0);
    @(posedge clk_i); #1;
    clear_req(1'b0);
`ifdef IP_CODMA_ARB_TIMEOUT_EN
    push(K_ERR, 1'b0, 64'd0);
    n_req = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (m0_error_o) break;
      if (s_read_o) n_req++;
    end
    chk("timeout_req_cycles", 64'(n_req), 64'd255);
    @(posedge clk_i); #1;
    chk("timeout_idle", 64'({m0_grant_o, s_read_o}), 64'd0);
`else
    n_req = 0;
    repeat (1000) begin
      @(posedge clk_i); #1;
      if (s_read_o) n_req++;
    end
    chk("no_wdog_req_cycles", 64'(n_req), 64'd1000);
    chk("no_wdog_still_req", 64'({m0_grant_o, s_read_o}), 64'd3);
    pulse_reset();
`endif

    repeat (3) @(posedge clk_i);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
